reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter W, default 8, register data width in bits.
REQ-002 Parameter D, default 4, register address width; the register file holds 2**D entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr_req  input  1  one-cycle pulse; restarts the clear sequence.
REQ-006 a_req  input  1  requester A (ALU writeback) write request.
REQ-007 a_addr  input  D  requester A destination register.
REQ-008 a_data  input  W  requester A write data.
REQ-009 a_gnt  output  1  combinational; A's request accepted this cycle.
REQ-010 b_req, b_addr, b_data, b_gnt  same widths and directions as A; requester B (load unit).
REQ-011 wr_en  output  1  registered; drives the register file write enable.
REQ-012 waddr  output  D  registered; drives the register file write address.
REQ-013 wdata  output  W  registered; drives the register file write data.
REQ-014 init_done  output  1  registered; high while the register file holds valid cleared-or-written contents.

Function
REQ-015 FSM states: INIT (clearing all entries) and RUN (arbitrating); a D-bit clear counter cnt and a 1-bit round-robin pointer rr (0 = A preferred, 1 = B preferred) are the only other state.
REQ-016 INIT: at each edge, wr_en<=1, waddr<=cnt, wdata<=0, cnt<=cnt+1; a_gnt=b_gnt=0 throughout INIT.
REQ-017 INIT->RUN at the edge where cnt==2**D-1 (last clear write presented); init_done<=1 at that same edge; cnt wraps to 0.
REQ-018 RUN, only one requester: its gnt=1 in the same cycle; at the next edge wr_en<=1, waddr/wdata<=its addr/data; rr unchanged.
REQ-019 RUN, both requesting: grant the side selected by rr, other gnt=0; rr toggles at that edge; the loser keeps requesting and is served next.
REQ-020 RUN, no request: wr_en<=0; waddr/wdata hold their previous values.
REQ-021 Requests are level-held; a requester drops req only after the cycle in which its gnt=1; addr and data are sampled only in the grant cycle.
REQ-022 Write latency: a request granted in cycle k appears on wr_en/waddr/wdata in cycle k+1; the register file commits it at the end of cycle k+1.
REQ-023 clr_req in RUN: no grants that cycle; at the edge state<=INIT, cnt<=0, init_done<=0, wr_en<=0; clearing begins the following edge.
REQ-024 clr_req in INIT: cnt<=0 and clearing restarts; no other effect.
REQ-025 Address 0 requests are granted and written like any other; no address is protected.
REQ-026 Throughput: at most one write per cycle; never two gnt high in the same cycle.

Reset
REQ-027 rst_n low asynchronously forces state=INIT, cnt=0, rr=0, wr_en=0, waddr=0, wdata=0, init_done=0; gnt outputs are 0 while rst_n is low.
REQ-028 Reset asserted mid-INIT or mid-RUN discards any in-flight granted write (wr_en drops immediately); after release, the full clear sequence reruns from address 0.
REQ-029 The first clear write (waddr=0) is presented at the first rising edge after rst_n deasserts.

Verification
REQ-030 Reset release, no requests -> wr_en=1 for 16 consecutive cycles with waddr 0..15, wdata=0; init_done rises with waddr=15; wr_en=0 afterwards.
REQ-031 RUN, a_req only, a_addr=3, a_data=8'h5A -> a_gnt=1 same cycle; next cycle wr_en=1, waddr=3, wdata=8'h5A.
REQ-032 RUN, both request continuously (A: addr 1/8'h11, B: addr 2/8'h22), rr=0 -> grants alternate A,B,A,B; writes alternate waddr 1,2,1,2.
REQ-033 a_req held during INIT -> a_gnt=0 for all 16 clear cycles; granted in the first RUN cycle.
REQ-034 clr_req pulse in RUN while b_req=1 -> b_gnt=0 that cycle; init_done falls; 16 clear writes follow; B is granted after init_done rises.
REQ-035 rst_n pulsed low mid-INIT at cnt=9 -> wr_en=0 and init_done=0 immediately; after release, clearing restarts at waddr=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: clears every entry after reset or clr_req, then
// arbitrates two write requesters round-robin into a single registered write port.
module reg_write_arbiter #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_req,
    input  logic         a_req,
    input  logic [D-1:0] a_addr,
    input  logic [W-1:0] a_data,
    output logic         a_gnt,
    input  logic         b_req,
    input  logic [D-1:0] b_addr,
    input  logic [W-1:0] b_data,
    output logic         b_gnt,
    output logic         wr_en,
    output logic [D-1:0] waddr,
    output logic [W-1:0] wdata,
    output logic         init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t       state;
    logic [D-1:0] cnt;
    logic         rr;
    logic         arb_active;

    // rr=0 favours A on contention, rr=1 favours B
    always_comb begin
        arb_active = rst_n && (state == RUN) && !clr_req;
        a_gnt      = arb_active && a_req && (!b_req || !rr);
        b_gnt      = arb_active && b_req && (!a_req || rr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            rr        <= 1'b0;
            wr_en     <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    wr_en <= 1'b1;
                    waddr <= cnt;
                    wdata <= '0;
                    if (clr_req) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) begin
                            state     <= RUN;
                            init_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state     <= INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                        wr_en     <= 1'b0;
                    end else if (a_gnt || b_gnt) begin
                        wr_en <= 1'b1;
                        waddr <= a_gnt ? a_addr : b_addr;
                        wdata <= a_gnt ? a_data : b_data;
                        if (a_req && b_req)
                            rr <= ~rr;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, hand-written clear/reset
// sequences, and randomized traffic checked against a behavioural model.
module tb_reg_write_arbiter;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int NREG = 1 << D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr_req = 1'b0;
    logic         a_req = 1'b0, b_req = 1'b0;
    logic [D-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         a_gnt, b_gnt, wr_en, init_done;
    logic [D-1:0] waddr;
    logic [W-1:0] wdata;

    reg_write_arbiter #(.W(W), .D(D)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: clearing progress, preference, expected write port
    bit         m_running, m_done, m_pref_b, m_wr;
    int         m_pos;
    logic [D-1:0] m_waddr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] rf_dut [NREG];
    logic [W-1:0] rf_mdl [NREG];

    logic s_a_gnt, s_b_gnt;

    typedef struct {
        logic a_req; logic [D-1:0] a_addr; logic [W-1:0] a_data;
        logic b_req; logic [D-1:0] b_addr; logic [W-1:0] b_data;
        logic clr;
        logic ea, eb, ewr; logic [D-1:0] eaddr; logic [W-1:0] edata; logic edone;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_running = 0; m_done = 0; m_pref_b = 0; m_wr = 0;
        m_pos = 0; m_waddr = '0; m_wdata = '0;
    endfunction

    // 0 = nobody, 1 = A, 2 = B
    function automatic int model_winner();
        if (!m_running || clr_req) return 0;
        if (a_req && b_req) return m_pref_b ? 2 : 1;
        if (a_req) return 1;
        if (b_req) return 2;
        return 0;
    endfunction

    function automatic void model_edge();
        int win;
        win = model_winner();
        if (!m_running) begin
            m_wr = 1; m_waddr = m_pos[D-1:0]; m_wdata = '0;
            if (clr_req) m_pos = 0;
            else if (m_pos == NREG - 1) begin
                m_pos = 0; m_running = 1; m_done = 1;
            end else m_pos = m_pos + 1;
        end else if (clr_req) begin
            m_running = 0; m_pos = 0; m_done = 0; m_wr = 0;
        end else if (win == 1) begin
            m_wr = 1; m_waddr = a_addr; m_wdata = a_data;
            if (b_req) m_pref_b = 1;
        end else if (win == 2) begin
            m_wr = 1; m_waddr = b_addr; m_wdata = b_data;
            if (a_req) m_pref_b = 0;
        end else m_wr = 0;
    endfunction

    // Called at a falling edge with inputs already applied; returns at the next falling edge
    task automatic step();
        int win;
        #1;
        win = model_winner();
        s_a_gnt = a_gnt;
        s_b_gnt = b_gnt;
        chk("mdl_a_gnt", a_gnt, (win == 1));
        chk("mdl_b_gnt", b_gnt, (win == 2));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("mdl_wr_en", wr_en, m_wr);
        chk("mdl_init_done", init_done, m_done);
        if (m_wr) begin
            chk("mdl_waddr", waddr, m_waddr);
            chk("mdl_wdata", wdata, m_wdata);
        end
        if (wr_en) rf_dut[waddr] = wdata;
        if (m_wr) rf_mdl[m_waddr] = m_wdata;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_seq();
        for (int i = 0; i < NREG; i++) begin
            step();
            chk("clr_a_gnt", s_a_gnt, 0);
            chk("clr_b_gnt", s_b_gnt, 0);
            chk("clr_wr_en", wr_en, 1);
            chk("clr_waddr", waddr, i);
            chk("clr_wdata", wdata, 0);
            chk("clr_init_done", init_done, (i == NREG - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf_dut[i] = 'x;
            rf_mdl[i] = 'x;
        end
        //             a  aad adat   b  bad bdat   clr  ea eb wr ad  data  done
        tbl[0]  = '{1, 3, 8'h5A, 0, 0, 8'h00, 0,   1, 0, 1, 3, 8'h5A, 1};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 0, 0, 3, 8'h5A, 1};
        tbl[2]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 0, 1, 1, 8'h11, 1};
        tbl[3]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0,   0, 1, 1, 2, 8'h22, 1};
        tbl[4]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 0, 1, 1, 8'h11, 1};
        tbl[5]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0,   0, 1, 1, 2, 8'h22, 1};
        tbl[6]  = '{1, 1, 8'h11, 0, 0, 8'h00, 0,   1, 0, 1, 1, 8'h11, 1};
        tbl[7]  = '{0, 0, 8'h00, 1, 0, 8'h77, 0,   0, 1, 1, 0, 8'h77, 1};
        tbl[8]  = '{1, 5, 8'hAA, 1, 6, 8'hBB, 0,   1, 0, 1, 5, 8'hAA, 1};
        tbl[9]  = '{0, 0, 8'h00, 1, 6, 8'hBB, 0,   0, 1, 1, 6, 8'hBB, 1};
        tbl[10] = '{1, 4, 8'h44, 0, 0, 8'h00, 0,   1, 0, 1, 4, 8'h44, 1};
        tbl[11] = '{1, 7, 8'h07, 1, 8, 8'h08, 0,   0, 1, 1, 8, 8'h08, 1};
        tbl[12] = '{1, 7, 8'h07, 0, 0, 8'h00, 0,   1, 0, 1, 7, 8'h07, 1};
        tbl[13] = '{0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 0, 0, 7, 8'h07, 1};
        tbl[14] = '{1, 7, 8'h07, 1, 2, 8'h22, 1,   0, 0, 0, 7, 8'h07, 0};

        model_reset();
        @(negedge clk);
        rst_pulse();

        // Full clear after reset release, then idle
        clear_seq();
        step();
        chk("idle_wr_en", wr_en, 0);

        // Directed vectors in RUN
        foreach (tbl[i]) begin
            a_req = tbl[i].a_req; a_addr = tbl[i].a_addr; a_data = tbl[i].a_data;
            b_req = tbl[i].b_req; b_addr = tbl[i].b_addr; b_data = tbl[i].b_data;
            clr_req = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_a_gnt", i), s_a_gnt, tbl[i].ea);
            chk($sformatf("tbl%0d_b_gnt", i), s_b_gnt, tbl[i].eb);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].ewr);
            chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].edata);
            chk($sformatf("tbl%0d_init_done", i), init_done, tbl[i].edone);
        end

        // clr_req while B waits: B held through the whole re-clear, then served
        clr_req = 0; a_req = 0;
        b_req = 1; b_addr = 4'hC; b_data = 8'hC3;
        clear_seq();
        step();
        chk("post_clr_b_gnt", s_b_gnt, 1);
        chk("post_clr_wr_en", wr_en, 1);
        chk("post_clr_waddr", waddr, 4'hC);
        chk("post_clr_wdata", wdata, 8'hC3);

        // Reset with a write in flight, A held during the clear
        b_req = 0;
        a_req = 1; a_addr = 4'h9; a_data = 8'h99;
        rst_pulse();
        clear_seq();
        step();
        chk("first_run_a_gnt", s_a_gnt, 1);
        step();
        chk("first_run_wr_en", wr_en, 1);
        chk("first_run_waddr", waddr, 4'h9);
        chk("first_run_wdata", wdata, 8'h99);

        // Reset mid-clear at cnt=9, clearing restarts from address 0
        a_req = 0;
        rst_pulse();
        for (int i = 0; i < 9; i++) step();
        chk("mid_init_waddr", waddr, 8);
        rst_pulse();
        clear_seq();

        // Randomized traffic, including clr_req in both phases
        for (int c = 0; c < 600; c++) begin
            if (s_a_gnt || !a_req) a_req = ($urandom_range(0, 2) != 0);
            if (s_b_gnt || !b_req) b_req = ($urandom_range(0, 2) != 0);
            a_addr = $urandom_range(0, NREG - 1);
            b_addr = $urandom_range(0, NREG - 1);
            a_data = $urandom_range(0, 255);
            b_data = $urandom_range(0, 255);
            clr_req = ($urandom_range(0, 59) == 0);
            step();
        end
        clr_req = 0; a_req = 0; b_req = 0;
        for (int i = 0; i < 3 * NREG && !m_done; i++) step();
        chk("final_init_done", init_done, 1);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("regfile_%0d", i), rf_dut[i], rf_mdl[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
